pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It generates stall and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC register. It covers load-use hazards, taken branches and jumps, multi-cycle data-memory accesses with a timeout watchdog, and a multi-cycle MDU operation. It sits beside the datapath. Its `StallD`/`FlushD` outputs drive the IF/ID register `enable` (1 = hold) and `clear` inputs.

## Interface
Parameters:
- `DMEM_TIMEOUT`, 16, max DWAIT cycles before abort; legal range 2..255
- `CNT_W`, 32, width of the performance counters

Ports:
- `clk`  in  1  pipeline clock
- `reset_n`  in  1  asynchronous, active-low reset
- `Rs1D`, `Rs2D`  in  5 each  source registers of the instruction in ID
- `RdE`  in  5  destination register of the instruction in EX
- `LoadE`  in  1  instruction in EX is a load
- `PCSrcE`  in  1  taken branch or jump resolved in EX
- `MduStartE`  in  1  instruction in EX is a multi-cycle MDU op
- `mdu_done`  in  1  MDU result valid this cycle
- `MemAccessM`  in  1  load or store in MEM
- `dmem_ready`  in  1  data memory completes access this cycle
- `StallF`, `StallD`, `StallE`, `StallM`  out  1 each  hold PC, IF/ID, ID/EX, EX/MEM
- `FlushD`, `FlushE`, `FlushM`, `FlushW`  out  1 each  synchronous bubble into IF/ID, ID/EX, EX/MEM, MEM/WB
- `bus_err`  out  1  one-cycle pulse on DMEM timeout
- `stall_cycles`  out  CNT_W  count of cycles with `StallF`=1
- `flush_events`  out  CNT_W  count of branch/jump flushes

## Operation
- State machine states: RUN, DWAIT, MDU. Reset state is RUN.
- All stall/flush outputs are combinational from state and inputs. All outputs are 0 in reset with idle inputs.
- RUN priority, highest first:
  1. `MemAccessM & !dmem_ready`:
     - Asserts `StallF/D/E/M` and `FlushW`.
     - Next state is DWAIT. Wait counter is set to 1.
  2. `MduStartE & !mdu_done`:
     - Asserts `StallF/D/E` and `FlushM`.
     - Next state is MDU.
  3. `PCSrcE`:
     - Asserts `FlushD` and `FlushE`. No stalls.
     - Increments `flush_events`.
     - A simultaneous load-use condition is ignored, because the ID instruction is on the wrong path.
  4. Load-use: `LoadE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D)`:
     - Asserts `StallF`, `StallD` and `FlushE`.
- DWAIT:
  - While `!dmem_ready`, asserts `StallF/D/E/M` and `FlushW`. The wait counter increments each cycle.
  - All other inputs, including `PCSrcE`, are ignored. The held EX instruction re-presents `PCSrcE` after release.
  - `dmem_ready`=1 causes all outputs to be 0 that cycle. Next state is RUN.
  - Wait counter equal to `DMEM_TIMEOUT` with `!dmem_ready`:
    - `bus_err`=1 that cycle.
    - Stalls release as if ready; load data is undefined.
    - Next state is RUN.
- MDU:
  - While `!mdu_done`, asserts `StallF/D/E` and `FlushM`.
  - `mdu_done` causes all outputs to be 0. Next state is RUN.
  - `PCSrcE` and `MemAccessM` are ignored. MEM holds only bubbles here.
- `stall_cycles` increments on every cycle with `StallF`=1.
- Both counters wrap modulo 2^CNT_W.
- Reset mid-DWAIT or mid-MDU: immediate return to RUN. Wait counter, counters and `bus_err` clear to 0.

## Timing
- Zero-cycle latency: decisions affect register loads on the same rising edge.
- Load-use costs exactly 1 stall cycle. Taken branch costs 2 bubbles (D, E).
- DWAIT with ready on wait-cycle N costs N stall cycles.
- Timeout fires on cycle `DMEM_TIMEOUT` of the stall, counting the RUN entry cycle as 1.
- `bus_err` is registered-free: it is high only in the timeout cycle. It is never high two cycles in a row.
- The wait counter is 8 bits and saturates; it never wraps.
- `mdu_done` in the same cycle as `MduStartE` causes no stall and no MDU entry.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - State enum (RUN=2'd0, DWAIT=2'd1, MDU=2'd2).
  - Shared with the debug/CSR readout.
- Sub-module `pipe_perf_counters`:
  - Holds the two CNT_W counters.
  - Inputs: `inc_stall`, `inc_flush`, `clk`, `reset_n`.

## Test plan
- Load-use: lw x5 in EX, `Rs1D`=5 → one cycle of `StallF=StallD=FlushE=1`. `stall_cycles` goes 0→1. Same with `RdE`=0 → no stall.
- Taken branch coincident with load-use hazard → `FlushD=FlushE=1`, `StallF=0`, `flush_events`=1.
- Load in MEM, `dmem_ready` low 3 cycles → `StallF/D/E/M` and `FlushW` high 3 cycles, released on the 4th (ready). `stall_cycles`=3.
- `dmem_ready` held low, `DMEM_TIMEOUT`=16 → `bus_err` single pulse on stall cycle 16, then RUN with stalls low.
- MDU op with `mdu_done` after 5 cycles plus `PCSrcE` asserted during the wait → `FlushM` high 5 cycles, no `FlushD`. `flush_events` unchanged.
- `reset_n` low in cycle 2 of DWAIT → all outputs 0 immediately; RUN on release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller and the debug/CSR readout.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        MDU   = 2'd2
    } state_t;

    localparam int WAIT_W = 8;

    // Wait counter must never wrap back to a small value mid-stall.
    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (v == {WAIT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the 5-stage datapath (master) and the hazard controller (slave).
// Latency: wires only.
// Backpressure: stall/flush fields are the backpressure into the pipeline registers.
// Ports: hazard inputs from ID/EX/MEM, stall/flush controls, bus_err, perf counters.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       RdE;
    logic             LoadE;
    logic             PCSrcE;
    logic             MduStartE;
    logic             mdu_done;
    logic             MemAccessM;
    logic             dmem_ready;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic             FlushW;
    logic             bus_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output Rs1D, Rs2D, RdE, LoadE, PCSrcE, MduStartE, mdu_done, MemAccessM, dmem_ready,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
        input  bus_err, stall_cycles, flush_events
    );

    modport slave (
        input  Rs1D, Rs2D, RdE, LoadE, PCSrcE, MduStartE, mdu_done, MemAccessM, dmem_ready,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
        output bus_err, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipe_perf_counters.sv
// Stall-cycle and branch-flush event counters, wrapping modulo 2^CNT_W.
// Latency: count visible the cycle after the increment request.
// Backpressure: none; counts every requested cycle.
// Ports: clk, reset_n, inc_stall, inc_flush -> stall_cycles, flush_events.
module pipe_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc_stall,
    input  logic             inc_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (inc_stall) stall_cycles <= stall_cycles + 1'b1;
            if (inc_flush) flush_events <= flush_events + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencing for load-use, taken branches, slow DMEM (with watchdog) and MDU ops.
// Latency: zero cycles; controls are combinational and act on the same rising edge.
// Backpressure: holds PC/IF/ID/ID/EX/EX/MEM while DMEM or MDU is busy, bubbles the stage behind.
// Ports: clk, reset_n, bus (slave side of pipe_hazard_ctrl_if).
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    pipe_hazard_ctrl_if.slave bus
);

    localparam logic [WAIT_W:0] TIMEOUT_CNT = (WAIT_W+1)'(DMEM_TIMEOUT);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [WAIT_W:0]   cur_wait;
    logic              dmem_req, mdu_req, load_use, timeout;
    logic              stall_f, stall_d, stall_e, stall_m;
    logic              flush_d, flush_e, flush_m, flush_w;
    logic              bus_err_c, inc_flush;

    assign dmem_req = bus.MemAccessM & ~bus.dmem_ready;
    assign mdu_req  = bus.MduStartE & ~bus.mdu_done;
    assign load_use = bus.LoadE && (bus.RdE != 5'd0) &&
                      ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

    // wait_cnt holds stall cycles already spent (RUN entry counts as 1), so the
    // current DWAIT cycle is number wait_cnt+1.
    assign cur_wait = {1'b0, wait_cnt} + 1'b1;
    assign timeout  = (cur_wait == TIMEOUT_CNT);

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_m   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_m   = 1'b0;
        flush_w   = 1'b0;
        bus_err_c = 1'b0;
        inc_flush = 1'b0;
        // Outputs are forced quiet while reset is asserted, whatever the inputs do.
        if (reset_n) begin
            case (state)
                RUN: begin
                    if (dmem_req) begin
                        {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
                        state_nxt = DWAIT;
                        wait_nxt  = WAIT_W'(1);
                    end else if (mdu_req) begin
                        {stall_f, stall_d, stall_e, flush_m} = 4'b1111;
                        state_nxt = MDU;
                    end else if (bus.PCSrcE) begin
                        // ID holds a wrong-path instruction, so any load-use on it is moot.
                        flush_d   = 1'b1;
                        flush_e   = 1'b1;
                        inc_flush = 1'b1;
                    end else if (load_use) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                DWAIT: begin
                    // PCSrcE is ignored: the held EX instruction presents it again after release.
                    if (bus.dmem_ready) begin
                        state_nxt = RUN;
                        wait_nxt  = '0;
                    end else if (timeout) begin
                        bus_err_c = 1'b1;
                        state_nxt = RUN;
                        wait_nxt  = '0;
                    end else begin
                        {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
                        wait_nxt = sat_inc(wait_cnt);
                    end
                end
                MDU: begin
                    if (bus.mdu_done) begin
                        state_nxt = RUN;
                    end else begin
                        {stall_f, stall_d, stall_e, flush_m} = 4'b1111;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    assign bus.StallF  = stall_f;
    assign bus.StallD  = stall_d;
    assign bus.StallE  = stall_e;
    assign bus.StallM  = stall_m;
    assign bus.FlushD  = flush_d;
    assign bus.FlushE  = flush_e;
    assign bus.FlushM  = flush_m;
    assign bus.FlushW  = flush_w;
    assign bus.bus_err = bus_err_c;

    pipe_perf_counters #(.CNT_W(CNT_W)) u_perf (
        .clk          (clk),
        .reset_n      (reset_n),
        .inc_stall    (stall_f),
        .inc_flush    (inc_flush),
        .stall_cycles (bus.stall_cycles),
        .flush_events (bus.flush_events)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();

    pipe_hazard_ctrl #(.DMEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW}
    logic [7:0] ctl;
    assign ctl = {bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                  bus.FlushD, bus.FlushE, bus.FlushM, bus.FlushW};

    localparam logic [7:0] CTL_IDLE = 8'b0000_0000;
    localparam logic [7:0] CTL_LU   = 8'b1100_0100;
    localparam logic [7:0] CTL_BR   = 8'b0000_1100;
    localparam logic [7:0] CTL_DW   = 8'b1111_0001;
    localparam logic [7:0] CTL_MDU  = 8'b1110_0010;

    task automatic idle();
        bus.Rs1D = 5'd0; bus.Rs2D = 5'd0; bus.RdE = 5'd0;
        bus.LoadE = 1'b0; bus.PCSrcE = 1'b0; bus.MduStartE = 1'b0;
        bus.mdu_done = 1'b0; bus.MemAccessM = 1'b0; bus.dmem_ready = 1'b0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1..3 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        #2;
        checks++;
        if (ctl !== CTL_IDLE) begin errors++; $display("FAIL reset_ctl got %b want %b", ctl, CTL_IDLE); end
        checks++;
        if (bus.bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err got %b want 0", bus.bus_err); end
        checks++;
        if (bus.stall_cycles !== 32'd0 || bus.flush_events !== 32'd0) begin
            errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", bus.stall_cycles, bus.flush_events);
        end
        step(); step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_load_use();
        bus.LoadE = 1'b1; bus.RdE = 5'd5; bus.Rs1D = 5'd5; bus.Rs2D = 5'd7;
        #2;
        checks++;
        if (ctl !== CTL_LU) begin errors++; $display("FAIL load_use_rs1 got %b want %b", ctl, CTL_LU); end
        step();
        idle();
        #2;
        checks++;
        if (bus.stall_cycles !== 32'd1) begin errors++; $display("FAIL load_use_count got %0d want 1", bus.stall_cycles); end
        checks++;
        if (ctl !== CTL_IDLE) begin errors++; $display("FAIL load_use_release got %b want %b", ctl, CTL_IDLE); end
        // x0 destination never creates a hazard
        bus.LoadE = 1'b1; bus.RdE = 5'd0; bus.Rs1D = 5'd0; bus.Rs2D = 5'd0;
        #1;
        checks++;
        if (ctl !== CTL_IDLE) begin errors++; $display("FAIL load_use_x0 got %b want %b", ctl, CTL_IDLE); end
        step();
        bus.LoadE = 1'b1; bus.RdE = 5'd9; bus.Rs1D = 5'd3; bus.Rs2D = 5'd9;
        #2;
        checks++;
        if (ctl !== CTL_LU) begin errors++; $display("FAIL load_use_rs2 got %b want %b", ctl, CTL_LU); end
        step();
        // non-load producer: no stall
        bus.LoadE = 1'b0;
        #2;
        checks++;
        if (ctl !== CTL_IDLE) begin errors++; $display("FAIL alu_no_stall got %b want %b", ctl, CTL_IDLE); end
        step();
        idle();
        checks++;
        if (bus.stall_cycles !== 32'd2) begin errors++; $display("FAIL load_use_total got %0d want 2", bus.stall_cycles); end
    endtask

    task automatic test_branch_over_load_use();
        bus.LoadE = 1'b1; bus.RdE = 5'd5; bus.Rs1D = 5'd5; bus.PCSrcE = 1'b1;
        #2;
        checks++;
        if (ctl !== CTL_BR) begin errors++; $display("FAIL branch_lu got %b want %b", ctl, CTL_BR); end
        step();
        idle();
        #2;
        checks++;
        if (bus.flush_events !== 32'd1) begin errors++; $display("FAIL branch_count got %0d want 1", bus.flush_events); end
        checks++;
        if (bus.stall_cycles !== 32'd2) begin errors++; $display("FAIL branch_no_stall got %0d want 2", bus.stall_cycles); end
    endtask

    task automatic test_dmem_wait();
        bus.MemAccessM = 1'b1; bus.dmem_ready = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c >= 2) bus.PCSrcE = 1'b1;  // must be ignored while waiting
            #2;
            checks++;
            if (ctl !== CTL_DW) begin errors++; $display("FAIL dwait_cycle%0d got %b want %b", c, ctl, CTL_DW); end
            step();
        end
        bus.dmem_ready = 1'b1;
        #2;
        checks++;
        if (ctl !== CTL_IDLE) begin errors++; $display("FAIL dwait_release got %b want %b", ctl, CTL_IDLE); end
        step();
        idle();
        #2;
        checks++;
        if (bus.stall_cycles !== 32'd5) begin errors++; $display("FAIL dwait_count got %0d want 5", bus.stall_cycles); end
        checks++;
        if (bus.flush_events !== 32'd1) begin errors++; $display("FAIL dwait_pcsrc_ignored got %0d want 1", bus.flush_events); end
        checks++;
        if (ctl !== CTL_IDLE) begin errors++; $display("FAIL dwait_back_run got %b want %b", ctl, CTL_IDLE); end
    endtask

    task automatic test_dmem_timeout();
        int bad_stall;
        int bad_err;
        bad_stall = 0;
        bad_err   = 0;
        bus.MemAccessM = 1'b1; bus.dmem_ready = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            #2;
            if (ctl !== CTL_DW) bad_stall++;
            if (bus.bus_err !== 1'b0) bad_err++;
            step();
        end
        checks++;
        if (bad_stall != 0) begin errors++; $display("FAIL timeout_stall_cycles got %0d bad cycles want 0", bad_stall); end
        checks++;
        if (bad_err != 0) begin errors++; $display("FAIL timeout_early_err got %0d pulses want 0", bad_err); end
        #2;
        checks++;
        if (bus.bus_err !== 1'b1) begin errors++; $display("FAIL timeout_pulse got %b want 1", bus.bus_err); end
        checks++;
        if (ctl !== CTL_IDLE) begin errors++; $display("FAIL timeout_release got %b want %b", ctl, CTL_IDLE); end
        step();
        bus.MemAccessM = 1'b0;
        #2;
        checks++;
        if (bus.bus_err !== 1'b0 || ctl !== CTL_IDLE) begin
            errors++; $display("FAIL timeout_after got err=%b ctl=%b want err=0 ctl=%b", bus.bus_err, ctl, CTL_IDLE);
        end
        checks++;
        if (bus.stall_cycles !== 32'd20) begin errors++; $display("FAIL timeout_count got %0d want 20", bus.stall_cycles); end
        step();
        idle();
    endtask

    task automatic test_mdu();
        bus.MduStartE = 1'b1; bus.mdu_done = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c >= 2) bus.PCSrcE = 1'b1;
            #2;
            checks++;
            if (ctl !== CTL_MDU) begin errors++; $display("FAIL mdu_cycle%0d got %b want %b", c, ctl, CTL_MDU); end
            step();
        end
        bus.mdu_done = 1'b1;
        #2;
        checks++;
        if (ctl !== CTL_IDLE) begin errors++; $display("FAIL mdu_release got %b want %b", ctl, CTL_IDLE); end
        step();
        idle();
        #2;
        checks++;
        if (bus.flush_events !== 32'd1) begin errors++; $display("FAIL mdu_pcsrc_ignored got %0d want 1", bus.flush_events); end
        checks++;
        if (bus.stall_cycles !== 32'd25) begin errors++; $display("FAIL mdu_count got %0d want 25", bus.stall_cycles); end
    endtask

    task automatic test_mdu_same_cycle();
        bus.MduStartE = 1'b1; bus.mdu_done = 1'b1;
        #2;
        checks++;
        if (ctl !== CTL_IDLE) begin errors++; $display("FAIL mdu_fast got %b want %b", ctl, CTL_IDLE); end
        step();
        bus.MduStartE = 1'b0; bus.mdu_done = 1'b0;
        #2;
        checks++;
        if (ctl !== CTL_IDLE) begin errors++; $display("FAIL mdu_fast_no_entry got %b want %b", ctl, CTL_IDLE); end
        step();
    endtask

    task automatic test_reset_mid_dwait();
        bus.MemAccessM = 1'b1; bus.dmem_ready = 1'b0;
        step();
        #2;
        checks++;
        if (ctl !== CTL_DW) begin errors++; $display("FAIL rst_mid_in_dwait got %b want %b", ctl, CTL_DW); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_IDLE || bus.bus_err !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outputs got ctl=%b err=%b want ctl=%b err=0", ctl, bus.bus_err, CTL_IDLE);
        end
        checks++;
        if (bus.stall_cycles !== 32'd0 || bus.flush_events !== 32'd0) begin
            errors++; $display("FAIL rst_mid_counters got %0d/%0d want 0/0", bus.stall_cycles, bus.flush_events);
        end
        idle();
        step();
        reset_n = 1'b1;
        step();
        #2;
        checks++;
        if (ctl !== CTL_IDLE) begin errors++; $display("FAIL rst_mid_run got %b want %b", ctl, CTL_IDLE); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_use();
        test_branch_over_load_use();
        test_dmem_wait();
        test_dmem_timeout();
        test_mdu();
        test_mdu_same_cycle();
        test_reset_mid_dwait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
